// File: rtl/hps_tx_pkg.sv
// Shared types and CRC helper for the HPS TX framer.
package hps_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD
    } tx_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One byte of CRC-8, MSB first, no reflection, no final xor.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Show-ahead byte FIFO: head byte is visible on o_rd_data whenever not empty.
// Level, full and empty are registered. A write to a full FIFO is accepted
// only when a read frees a slot in the same cycle; otherwise it is dropped.
module tx_byte_fifo #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic [7:0]         i_wr_data,
    input  logic               i_rd_en,
    output logic [7:0]         o_rd_data,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_wr_drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_full;
    logic               r_empty;

    logic               w_wr;
    logic               w_rd;
    logic [LEVEL_W-1:0] w_level_d;

    // Accept/read qualification and next level.
    always_comb begin
        w_rd      = i_rd_en && !r_empty;
        w_wr      = i_wr_en && (!r_full || w_rd);
        w_level_d = r_level;
        unique case ({w_wr, w_rd})
            2'b10:   w_level_d = r_level + LEVEL_W'(1);
            2'b01:   w_level_d = r_level - LEVEL_W'(1);
            default: w_level_d = r_level;
        endcase
    end

    // Pointers and registered status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_d;
            r_full  <= (w_level_d == LEVEL_W'(DEPTH));
            r_empty <= (w_level_d == '0);
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_wr_drop = i_wr_en && !w_wr;

endmodule

// File: rtl/hps_tx_framer.sv
// HPS TX framer: buffers bytes from the register bank and emits
// length-delimited frames on a valid/ready byte stream, followed by a
// programmable guard gap.
// Optional: `define TX_CRC8_EN appends a CRC-8 byte carrying mod_eof.
module hps_tx_framer
    import hps_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         data_tx,
    input  logic               wren_fifo_tx,
    input  logic [7:0]         size_fifo_tx,
    input  logic               start_tx,
    input  logic [31:0]        guard_interval,
    output logic               ready_tx,
    output logic [7:0]         mod_data,
    output logic               mod_valid,
    input  logic               mod_ready,
    output logic               mod_sof,
    output logic               mod_eof,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow,
    output logic               start_err
);

    tx_state_e          r_state, w_state_d;
    logic               r_pending, w_pending_d;
    logic [7:0]         r_len, w_len_d;
    logic [7:0]         r_rem, w_rem_d;
    logic [31:0]        r_gap, w_gap_d;
    logic               r_ready, w_ready_d;
    logic [7:0]         r_data, w_data_d;
    logic               r_valid, w_valid_d;
    logic               r_sof, w_sof_d;
    logic               r_eof, w_eof_d;
    logic               r_ovf, w_ovf_d;
    logic               r_serr, w_serr_d;
`ifdef TX_CRC8_EN
    logic [7:0]         r_crc, w_crc_d;
    logic               r_crc_ph, w_crc_ph_d;
`endif

    logic               w_fifo_rd;
    logic [7:0]         w_fifo_data;
    logic [LEVEL_W-1:0] w_fifo_level;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_wr_drop;
    logic               w_start_ok;
    logic               w_hs;
    logic               w_to_guard;

    tx_byte_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_wr_en   (wren_fifo_tx),
        .i_wr_data (data_tx),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_data),
        .o_level   (w_fifo_level),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_wr_drop (w_wr_drop)
    );

    // Next-state, datapath and output computation.
    always_comb begin
        w_state_d   = r_state;
        w_pending_d = r_pending;
        w_len_d     = r_len;
        w_rem_d     = r_rem;
        w_gap_d     = r_gap;
        w_data_d    = r_data;
        w_valid_d   = r_valid;
        w_sof_d     = r_sof;
        w_eof_d     = r_eof;
        w_ovf_d     = r_ovf;
        w_fifo_rd   = 1'b0;
        w_to_guard  = 1'b0;
`ifdef TX_CRC8_EN
        w_crc_d     = r_crc;
        w_crc_ph_d  = r_crc_ph;
`endif
        w_hs        = r_valid && mod_ready;
        w_start_ok  = start_tx && (r_state == IDLE) && !r_pending && (size_fifo_tx != 8'd0);
        w_serr_d    = start_tx && !w_start_ok;

        if (w_start_ok) begin
            w_pending_d = 1'b1;
            w_len_d     = size_fifo_tx;
            w_ovf_d     = 1'b0;
        end
        // A dropped write after an accepted start still reports the loss.
        if (w_wr_drop) w_ovf_d = 1'b1;

        unique case (r_state)
            IDLE: begin
                // Level is registered, so a same-cycle write counts next cycle.
                if (r_pending && !w_fifo_empty && (w_fifo_level >= LEVEL_W'(r_len))) begin
                    w_state_d = SEND;
                    w_fifo_rd = 1'b1;
                    w_data_d  = w_fifo_data;
                    w_valid_d = 1'b1;
                    w_sof_d   = 1'b1;
                    w_rem_d   = r_len;
`ifdef TX_CRC8_EN
                    w_eof_d    = 1'b0;
                    w_crc_d    = CRC8_INIT;
                    w_crc_ph_d = 1'b0;
`else
                    w_eof_d   = (r_len == 8'd1);
`endif
                end
            end
            SEND: begin
                if (w_hs) begin
                    w_sof_d = 1'b0;
`ifdef TX_CRC8_EN
                    if (r_crc_ph) begin
                        w_to_guard = 1'b1;
                    end else begin
                        w_crc_d = crc8_step(r_crc, r_data);
                        if (r_rem == 8'd1) begin
                            w_data_d   = crc8_step(r_crc, r_data);
                            w_eof_d    = 1'b1;
                            w_crc_ph_d = 1'b1;
                        end else begin
                            w_fifo_rd = 1'b1;
                            w_data_d  = w_fifo_data;
                            w_rem_d   = r_rem - 8'd1;
                        end
                    end
`else
                    if (r_rem == 8'd1) begin
                        w_to_guard = 1'b1;
                    end else begin
                        w_fifo_rd = 1'b1;
                        w_data_d  = w_fifo_data;
                        w_rem_d   = r_rem - 8'd1;
                        w_eof_d   = (r_rem == 8'd2);
                    end
`endif
                end
            end
            GUARD: begin
                if (r_gap == 32'd0) w_state_d = IDLE;
                else                w_gap_d   = r_gap - 32'd1;
            end
            default: w_state_d = IDLE;
        endcase

        if (w_to_guard) begin
            w_state_d   = GUARD;
            w_gap_d     = guard_interval;
            w_valid_d   = 1'b0;
            w_sof_d     = 1'b0;
            w_eof_d     = 1'b0;
            w_pending_d = 1'b0;
        end

        w_ready_d = (w_state_d == IDLE) && !w_pending_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_len     <= 8'd0;
            r_rem     <= 8'd0;
            r_gap     <= 32'd0;
            r_ready   <= 1'b1;
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_ovf     <= 1'b0;
            r_serr    <= 1'b0;
`ifdef TX_CRC8_EN
            r_crc     <= CRC8_INIT;
            r_crc_ph  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_pending <= w_pending_d;
            r_len     <= w_len_d;
            r_rem     <= w_rem_d;
            r_gap     <= w_gap_d;
            r_ready   <= w_ready_d;
            r_data    <= w_data_d;
            r_valid   <= w_valid_d;
            r_sof     <= w_sof_d;
            r_eof     <= w_eof_d;
            r_ovf     <= w_ovf_d;
            r_serr    <= w_serr_d;
`ifdef TX_CRC8_EN
            r_crc     <= w_crc_d;
            r_crc_ph  <= w_crc_ph_d;
`endif
        end
    end

    assign ready_tx   = r_ready;
    assign mod_data   = r_data;
    assign mod_valid  = r_valid;
    assign mod_sof    = r_sof;
    assign mod_eof    = r_eof;
    assign fifo_level = w_fifo_level;
    assign overflow   = r_ovf;
    assign start_err  = r_serr;

endmodule
